sad_compare: RTL and testbench
==============================

SAD_COMPARE -- requirements
Module: sad_compare

Parameters
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter BLK, default 16, block edge in pixels (power of 2, 4..16).
REQ-003 SHALL have parameter PPW, default 2, pixels per memory word (power of 2, divides BLK).
REQ-004 SHALL have parameter ACC_W, default 18, accumulator width (>= PIX_W+2*log2(BLK)).
NW = BLK*BLK/PPW words per block; AW = log2(NW); OW = log2(BLK).

Interface
REQ-005 SHALL have ports: one clock; reset is asynchronous and active-low: clk in 1, clock, all logic on rising edge; reset_n in 1, async active-low reset.
REQ-006 en in 1; start pulse, sampled only in IDLE.
REQ-007 rdy out 1; high only in IDLE.
REQ-008 early_term in 1, abort-on-exceed mode; oldaccum in ACC_W, best SAD so far; both latched at start.
REQ-009 baddr out AW; bq in PPW*PIX_W; current-block RAM, bq = RAM[baddr of previous cycle].
REQ-010 mreq out 1; mx, my out OW each; mwait in 1; previous-frame request, accepted when mreq && !mwait.
REQ-011 mvalid in 1; mq in PPW*PIX_W; in-order responses, >= 1 cycle after acceptance.
REQ-012 waddr out AW; wdata out PPW*(PIX_W+1); wren out 1; residual write port.
REQ-013 accum out ACC_W; valid out 1; better out 1; aborted out 1.

Function
REQ-014 Word k: row k/(BLK/PPW), first column (k mod (BLK/PPW))*PPW; lane 0 (LSBs) leftmost pixel.
REQ-015 States: IDLE, RUN, DRAIN, DONE; en in IDLE -> RUN, latch early_term/oldaccum, clear accum, req_cnt, rsp_cnt, outstanding, aborted, better.
REQ-016 RUN: mreq=1 while req_cnt<NW, mx/my = word req_cnt coords; req_cnt increments on acceptance; mreq=0 after NW accepted.
REQ-017 baddr = rsp_cnt + mvalid (combinational); baddr=0 in IDLE; thus bq aligns with the mvalid word.
REQ-018 On mvalid in RUN: accum += sum over lanes |bq_i - mq_i|; rsp_cnt++; next cycle wren=1, waddr=rsp_cnt (old), wdata lane i = bq_i - mq_i as (PIX_W+1)-bit two's complement.
REQ-019 Outstanding count = accepted - received; simultaneous accept and mvalid leaves it unchanged.
REQ-020 After NW-th response: DONE next cycle with final accum.
REQ-021 early_term=1 and updated accum >= latched oldaccum before word NW: enter DRAIN, mreq=0, set aborted.
REQ-022 DRAIN: further mvalid consumed silently (no accum change, no wren); DONE when outstanding=0.
REQ-023 DONE lasts one cycle: valid=1; better = !aborted && accum < oldaccum (equal is not better); then IDLE.
REQ-024 accum, better, aborted hold after DONE until next start; en outside IDLE ignored; mvalid in IDLE ignored.
REQ-025 Accumulation SHALL not overflow for legal parameters; no saturation logic.

Reset
REQ-026 reset_n low: state IDLE, rdy=1, mreq=0, wren=0, valid=0, better=0, aborted=0, accum=0, baddr=waddr=0, mx=my=0, wdata=0, all counters 0.
REQ-027 Reset mid-operation aborts without valid; responses arriving after reset are ignored.

Verification (defaults, NW=128)
REQ-028 Identical blocks, no wait, oldaccum=100 -> 128 wren with wdata=0, accum=0, better=1, one valid pulse.
REQ-029 Cur all 1, prev all 0, oldaccum=18'h3FFFF, mwait toggling, latency 1-4 -> accum=256, better=1, waddr 0..127 in order.
REQ-030 early_term=1, cur 10, prev 0, oldaccum=50 -> abort after word 2, accum=60, aborted=1, better=0, wren only for words 0-2, valid after outstanding drained.
REQ-031 Same data with early_term=0 -> accum=2560, aborted=0, better=0.
REQ-032 Cur 0, prev 255 -> wdata lanes 9'h101, accum=65280.
REQ-033 Reset after 40 responses, then late mvalid -> rdy=1, accum=0, no wren; new run gives correct result.

Source files
------------

// File: rtl/sad_compare.sv
// Block sum-of-absolute-differences engine.
// Streams one BLKxBLK block of the previous frame through a request/response
// port, pairs each returned word with the matching current-block RAM word,
// accumulates |cur - prev|, writes signed residuals and compares the total
// against a running best. Optional early termination stops requesting as soon
// as the partial sum can no longer win, then drains in-flight responses.
module sad_compare #(
  parameter int PIX_W = 8,
  parameter int BLK   = 16,
  parameter int PPW   = 2,
  parameter int ACC_W = 18
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  output logic                              rdy,
  input  logic                              early_term,
  input  logic [ACC_W-1:0]                  oldaccum,
  output logic [$clog2(BLK*BLK/PPW)-1:0]    baddr,
  input  logic [PPW*PIX_W-1:0]              bq,
  output logic                              mreq,
  output logic [$clog2(BLK)-1:0]            mx,
  output logic [$clog2(BLK)-1:0]            my,
  input  logic                              mwait,
  input  logic                              mvalid,
  input  logic [PPW*PIX_W-1:0]              mq,
  output logic [$clog2(BLK*BLK/PPW)-1:0]    waddr,
  output logic [PPW*(PIX_W+1)-1:0]          wdata,
  output logic                              wren,
  output logic [ACC_W-1:0]                  accum,
  output logic                              valid,
  output logic                              better,
  output logic                              aborted
);

  localparam int NW  = BLK * BLK / PPW;
  localparam int AW  = $clog2(NW);
  localparam int OW  = $clog2(BLK);
  localparam int CW  = AW + 1;
  localparam int DW  = PIX_W + 1;
  localparam int unsigned WPR = BLK / PPW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state_reg;
  logic                   et_reg;
  logic [ACC_W-1:0]       old_reg;
  logic [ACC_W-1:0]       accum_reg;
  logic [CW-1:0]          req_cnt_reg;
  logic [CW-1:0]          rsp_cnt_reg;
  logic [CW-1:0]          outst_reg;
  logic                   aborted_reg;
  logic                   better_reg;
  logic                   valid_reg;
  logic                   wren_reg;
  logic [AW-1:0]          waddr_reg;
  logic [PPW*DW-1:0]      wdata_reg;

  logic [DW-1:0]          diff_lane [PPW];
  logic [DW-1:0]          abs_lane  [PPW];
  logic [PPW*DW-1:0]      diff_word;
  logic [ACC_W-1:0]       sad_sum;
  logic [ACC_W-1:0]       accum_next;
  logic [CW-1:0]          outst_next;
  logic                   accept;
  logic                   last_word;
  logic [AW-1:0]          req_idx;

  // Per-lane signed difference and magnitude; lane 0 sits in the LSBs.
  generate
    for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
      logic [PIX_W-1:0] b_pix;
      logic [PIX_W-1:0] m_pix;
      assign b_pix = bq[gi*PIX_W +: PIX_W];
      assign m_pix = mq[gi*PIX_W +: PIX_W];
      assign diff_lane[gi] = {1'b0, b_pix} - {1'b0, m_pix};
      assign abs_lane[gi]  = diff_lane[gi][PIX_W] ? (~diff_lane[gi] + DW'(1)) : diff_lane[gi];
      assign diff_word[gi*DW +: DW] = diff_lane[gi];
    end
  endgenerate

  // Sum of absolute differences across all lanes of the current word.
  always_comb begin
    sad_sum = '0;
    for (int i = 0; i < PPW; i++) begin
      sad_sum = sad_sum + ACC_W'(abs_lane[i]);
    end
  end

  assign accum_next = accum_reg + sad_sum;
  assign mreq       = (state_reg == RUN) && (req_cnt_reg < CW'(NW));
  assign accept     = mreq && !mwait;
  assign outst_next = outst_reg + CW'(accept) - CW'(mvalid);
  assign last_word  = (rsp_cnt_reg == CW'(NW - 1));
  assign req_idx    = req_cnt_reg[AW-1:0];

  // Request coordinates follow raster order of words within the block.
  assign mx = OW'((32'(req_idx) % WPR) * PPW);
  assign my = OW'(32'(req_idx) / WPR);

  // Look one word ahead when a response lands so the registered RAM read
  // returns the current-block word that pairs with the next response.
  assign baddr = (state_reg == RUN) ? (rsp_cnt_reg[AW-1:0] + AW'(mvalid)) : '0;

  assign rdy     = (state_reg == IDLE);
  assign accum   = accum_reg;
  assign better  = better_reg;
  assign aborted = aborted_reg;
  assign valid   = valid_reg;
  assign wren    = wren_reg;
  assign waddr   = waddr_reg;
  assign wdata   = wdata_reg;

  // Control FSM with accumulator, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      et_reg      <= 1'b0;
      old_reg     <= '0;
      accum_reg   <= '0;
      req_cnt_reg <= '0;
      rsp_cnt_reg <= '0;
      outst_reg   <= '0;
      aborted_reg <= 1'b0;
      better_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      wren_reg    <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
    end else begin
      wren_reg  <= 1'b0;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en) begin
            state_reg   <= RUN;
            et_reg      <= early_term;
            old_reg     <= oldaccum;
            accum_reg   <= '0;
            req_cnt_reg <= '0;
            rsp_cnt_reg <= '0;
            outst_reg   <= '0;
            aborted_reg <= 1'b0;
            better_reg  <= 1'b0;
          end
        end
        RUN: begin
          outst_reg <= outst_next;
          if (accept) begin
            req_cnt_reg <= req_cnt_reg + CW'(1);
          end
          if (mvalid) begin
            accum_reg   <= accum_next;
            rsp_cnt_reg <= rsp_cnt_reg + CW'(1);
            wren_reg    <= 1'b1;
            waddr_reg   <= rsp_cnt_reg[AW-1:0];
            wdata_reg   <= diff_word;
            if (last_word) begin
              state_reg  <= DONE;
              valid_reg  <= 1'b1;
              better_reg <= (accum_next < old_reg);
            end else if (et_reg && (accum_next >= old_reg)) begin
              state_reg   <= DRAIN;
              aborted_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          outst_reg <= outst_next;
          if (mvalid) begin
            rsp_cnt_reg <= rsp_cnt_reg + CW'(1);
          end
          if (outst_next == '0) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sad_compare.sv
// Randomized self-checking bench for sad_compare: current-block RAM model,
// in-order previous-frame responder with random wait/latency, and a
// word-by-word SAD reference computed straight from the pixel arrays.
module tb_sad_compare;
  localparam int PIX_W = 8;
  localparam int BLK   = 16;
  localparam int PPW   = 2;
  localparam int ACC_W = 18;
  localparam int NW    = BLK * BLK / PPW;
  localparam int AW    = $clog2(NW);
  localparam int OW    = $clog2(BLK);
  localparam int WPR   = BLK / PPW;
  localparam int DW    = PIX_W + 1;

  logic                   clk;
  logic                   reset_n;
  logic                   en;
  logic                   rdy;
  logic                   early_term;
  logic [ACC_W-1:0]       oldaccum;
  logic [AW-1:0]          baddr;
  logic [PPW*PIX_W-1:0]   bq;
  logic                   mreq;
  logic [OW-1:0]          mx;
  logic [OW-1:0]          my;
  logic                   mwait;
  logic                   mvalid;
  logic [PPW*PIX_W-1:0]   mq;
  logic [AW-1:0]          waddr;
  logic [PPW*DW-1:0]      wdata;
  logic                   wren;
  logic [ACC_W-1:0]       accum;
  logic                   valid;
  logic                   better;
  logic                   aborted;

  sad_compare #(.PIX_W(PIX_W), .BLK(BLK), .PPW(PPW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .rdy(rdy),
    .early_term(early_term), .oldaccum(oldaccum),
    .baddr(baddr), .bq(bq),
    .mreq(mreq), .mx(mx), .my(my), .mwait(mwait),
    .mvalid(mvalid), .mq(mq),
    .waddr(waddr), .wdata(wdata), .wren(wren),
    .accum(accum), .valid(valid), .better(better), .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [PIX_W-1:0] cur_pix  [BLK*BLK];
  logic [PIX_W-1:0] prev_pix [BLK*BLK];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PPW*PIX_W-1:0] cur_word(input int k);
    logic [PPW*PIX_W-1:0] w;
    int row = k / WPR;
    int col = (k % WPR) * PPW;
    for (int i = 0; i < PPW; i++) w[i*PIX_W +: PIX_W] = cur_pix[row*BLK + col + i];
    return w;
  endfunction

  function automatic logic [PPW*PIX_W-1:0] prev_word(input int x, input int y);
    logic [PPW*PIX_W-1:0] w;
    for (int i = 0; i < PPW; i++) w[i*PIX_W +: PIX_W] = prev_pix[y*BLK + x + i];
    return w;
  endfunction

  // Current-block RAM: one-cycle registered read.
  always @(posedge clk) bq <= cur_word(int'(baddr));

  // Previous-frame responder: in-order, latency >= 1 cycle after acceptance.
  typedef struct { int ready; int x; int y; } rq_t;
  rq_t rq[$];
  rq_t resp_r;
  int  edge_no = 0;
  int  last_ready = 0;
  int  acc_idx = 0;
  bit  wait_mode = 1'b0;
  int  lat_min = 1;
  int  lat_max = 1;

  always @(negedge clk) begin
    edge_no++;
    mvalid = 1'b0;
    mq = '0;
    if (rq.size() > 0 && rq[0].ready <= edge_no) begin
      resp_r = rq.pop_front();
      mvalid = 1'b1;
      mq = prev_word(resp_r.x, resp_r.y);
    end
    mwait = wait_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (reset_n && mreq && !mwait) begin
      chk("mx", 64'(mx), 64'((acc_idx % WPR) * PPW));
      chk("my", 64'(my), 64'(acc_idx / WPR));
      resp_r.x = int'(mx);
      resp_r.y = int'(my);
      resp_r.ready = edge_no + int'($urandom_range(lat_min, lat_max));
      if (resp_r.ready <= last_ready) resp_r.ready = last_ready + 1;
      last_ready = resp_r.ready;
      rq.push_back(resp_r);
      acc_idx++;
    end
  end

  // Reference model: expected residual writes and final result.
  typedef struct { int addr; logic [PPW*DW-1:0] data; } wr_t;
  wr_t              exp_wr[$];
  wr_t              wr_r;
  logic [ACC_W-1:0] exp_accum;
  bit               exp_better;
  bit               exp_aborted;
  int               mode = 0;
  int               valid_cnt = 0;
  int               wr_cnt = 0;
  bit               valid_d = 1'b0;

  task automatic build_model(input bit et, input logic [ACC_W-1:0] old);
    int acc = 0;
    exp_wr.delete();
    exp_aborted = 1'b0;
    for (int k = 0; k < NW; k++) begin
      wr_t w;
      int row = k / WPR;
      int col = (k % WPR) * PPW;
      for (int i = 0; i < PPW; i++) begin
        int c = int'(cur_pix[row*BLK + col + i]);
        int p = int'(prev_pix[row*BLK + col + i]);
        acc += (c > p) ? (c - p) : (p - c);
        w.data[i*DW +: DW] = DW'(c - p);
      end
      w.addr = k;
      exp_wr.push_back(w);
      if (k < NW - 1 && et && acc >= int'(old)) begin
        exp_aborted = 1'b1;
        break;
      end
    end
    exp_accum  = ACC_W'(acc);
    exp_better = !exp_aborted && (acc < int'(old));
  endtask

  // Compare process: every residual write and every result pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wren) begin
        wr_cnt++;
        if (mode == 0 || exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wren: waddr %0d wdata %h while no write expected", waddr, wdata);
        end else begin
          wr_r = exp_wr.pop_front();
          chk("waddr", 64'(waddr), 64'(wr_r.addr));
          chk("wdata", 64'(wdata), 64'(wr_r.data));
        end
      end
      if (valid) begin
        valid_cnt++;
        if (mode == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: valid=1 while no result expected");
        end else begin
          chk("result_accum", 64'(accum), 64'(exp_accum));
          chk("result_better", 64'(better), 64'(exp_better));
          chk("result_aborted", 64'(aborted), 64'(exp_aborted));
        end
      end
      if (valid && valid_d) begin
        checks++;
        errors++;
        $display("FAIL valid_width: valid high 2 cycles, required 1");
      end
      valid_d = valid;
    end else begin
      valid_d = 1'b0;
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_rdy"}, 64'(rdy), 64'd1);
    chk({tag, "_mreq"}, 64'(mreq), 64'd0);
    chk({tag, "_wren"}, 64'(wren), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_better"}, 64'(better), 64'd0);
    chk({tag, "_aborted"}, 64'(aborted), 64'd0);
    chk({tag, "_accum"}, 64'(accum), 64'd0);
    chk({tag, "_baddr"}, 64'(baddr), 64'd0);
    chk({tag, "_waddr"}, 64'(waddr), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    chk({tag, "_mx"}, 64'(mx), 64'd0);
    chk({tag, "_my"}, 64'(my), 64'd0);
  endtask

  task automatic start_run(input bit et, input logic [ACC_W-1:0] old);
    mode = 1;
    valid_cnt = 0;
    wr_cnt = 0;
    acc_idx = 0;
    @(negedge clk);
    en = 1'b1;
    early_term = et;
    oldaccum = old;
    @(negedge clk);
    en = 1'b0;
    early_term = ~et;
    oldaccum = ~old;
  endtask

  task automatic do_run(input string name, input bit et, input logic [ACC_W-1:0] old,
                        input int lit_accum, input int lit_writes);
    int stray;
    build_model(et, old);
    if (lit_accum >= 0) chk({name, "_model_accum"}, 64'(exp_accum), 64'(lit_accum));
    if (lit_writes >= 0) chk({name, "_model_writes"}, 64'(exp_wr.size()), 64'(lit_writes));
    start_run(et, old);
    stray = int'($urandom_range(3, 200));
    for (int n = 0; n < 5000 && valid_cnt == 0; n++) begin
      @(negedge clk);
      en = (n == stray && !rdy) ? 1'b1 : 1'b0;
    end
    en = 1'b0;
    if (valid_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no valid within 5000 cycles", name);
    end
    repeat (3) @(negedge clk);
    chk({name, "_valid_pulses"}, 64'(valid_cnt), 64'd1);
    chk({name, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    chk({name, "_rdy_after"}, 64'(rdy), 64'd1);
    chk({name, "_accum_hold"}, 64'(accum), 64'(exp_accum));
    chk({name, "_better_hold"}, 64'(better), 64'(exp_better));
    chk({name, "_aborted_hold"}, 64'(aborted), 64'(exp_aborted));
    if (lit_accum >= 0) chk({name, "_dut_accum"}, 64'(accum), 64'(lit_accum));
    if (lit_writes >= 0) chk({name, "_dut_writes"}, 64'(wr_cnt), 64'(lit_writes));
    mode = 0;
    for (int n = 0; n < 500 && rq.size() > 0; n++) @(negedge clk);
  endtask

  task automatic fill_const(input int c, input int p);
    for (int i = 0; i < BLK*BLK; i++) begin
      cur_pix[i]  = PIX_W'(c);
      prev_pix[i] = PIX_W'(p);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < BLK*BLK; i++) begin
      cur_pix[i]  = PIX_W'($urandom);
      prev_pix[i] = PIX_W'($urandom);
    end
  endtask

  initial begin
    int wr_before;
    logic [ACC_W-1:0] full_sad;
    reset_n = 1'b0;
    en = 1'b0;
    early_term = 1'b0;
    oldaccum = '0;
    fill_const(0, 0);
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identical blocks: all-zero residuals, SAD 0 beats 100.
    fill_rand();
    for (int i = 0; i < BLK*BLK; i++) prev_pix[i] = cur_pix[i];
    wait_mode = 1'b0; lat_min = 1; lat_max = 1;
    do_run("identical", 1'b0, 18'd100, 0, 128);
    chk("identical_better_lit", 64'(better), 64'd1);

    // Cur 1, prev 0, toggling wait and latency 1-4.
    fill_const(1, 0);
    wait_mode = 1'b1; lat_min = 1; lat_max = 4;
    do_run("ones", 1'b0, 18'h3FFFF, 256, 128);
    chk("ones_better_lit", 64'(better), 64'd1);

    // Early termination after word 2.
    fill_const(10, 0);
    wait_mode = 1'b0; lat_min = 1; lat_max = 3;
    do_run("abort", 1'b1, 18'd50, 60, 3);
    chk("abort_aborted_lit", 64'(aborted), 64'd1);
    chk("abort_better_lit", 64'(better), 64'd0);

    // Same data without early termination.
    do_run("noabort", 1'b0, 18'd50, 2560, 128);
    chk("noabort_aborted_lit", 64'(aborted), 64'd0);

    // Maximum negative residual.
    fill_const(0, 255);
    wait_mode = 1'b1; lat_min = 1; lat_max = 2;
    do_run("maxdiff", 1'b0, 18'h3FFFF, 65280, 128);

    // Equal to the best so far is not better.
    fill_rand();
    build_model(1'b0, 18'h3FFFF);
    full_sad = exp_accum;
    do_run("equal", 1'b0, full_sad, -1, 128);
    chk("equal_better_lit", 64'(better), 64'd0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      fill_rand();
      wait_mode = r[0];
      lat_min = 1;
      lat_max = 1 + (r % 4);
      do_run("random", 1'($urandom_range(0, 1)), ACC_W'($urandom_range(0, 30000)), -1, -1);
    end

    // Reset in the middle of a run with responses still in flight.
    fill_rand();
    wait_mode = 1'b0; lat_min = 2; lat_max = 5;
    build_model(1'b0, 18'h3FFFF);
    start_run(1'b0, 18'h3FFFF);
    for (int n = 0; n < 2000 && wr_cnt < 40; n++) @(negedge clk);
    chk("midreset_reached40", 64'(wr_cnt >= 40), 64'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    mode = 0;
    exp_wr.delete();
    repeat (2) @(negedge clk);
    check_reset_state("midreset");
    #2;
    reset_n = 1'b1;
    wr_before = wr_cnt;
    for (int n = 0; n < 500 && rq.size() > 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("midreset_rdy", 64'(rdy), 64'd1);
    chk("midreset_accum", 64'(accum), 64'd0);
    chk("midreset_no_wren", 64'(wr_cnt - wr_before), 64'd0);
    wait_mode = 1'b1; lat_min = 1; lat_max = 3;
    do_run("after_reset", 1'b0, 18'h3FFFF, -1, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
